data_mem_responder: RTL and testbench

- Memory-side responder for the MIPS datapath's load/store port.
- Accepts one word-wide read or write request at a time from the datapath (the initiator).
- Services the request after a programmable number of wait states and returns a response with data and an error flag.
- Holds the data memory internally. Gives the datapath bench a realistic multi-cycle memory to run against.

---
 rtl/mips_mem_pkg.sv | 32 +++
 rtl/data_mem_responder_ram.sv | 44 ++++
 rtl/data_mem_responder.sv | 152 +++++++++++++++
 tb/tb_data_mem_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and helpers for the datapath data-memory responder:
// FSM state encoding, byte-enable width and a constant log2 helper.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam int unsigned DEFAULT_BIT_WIDTH = 32;
  localparam int unsigned BE_WIDTH          = DEFAULT_BIT_WIDTH / 8;

  function automatic int unsigned be_width_f(input int unsigned bit_width);
    return bit_width / 8;
  endfunction

  // Ceiling log2; returns 0 for values 0 and 1.
  function automatic int unsigned clog2_f(input int unsigned value);
    int unsigned result;
    int unsigned rem;
    result = 0;
    rem    = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/data_mem_responder_ram.sv
// Single-port synchronous word RAM with per-byte write enables and a
// registered read port. Contents are never reset.
module data_mem_ram
  import mips_mem_pkg::*;
#(
  parameter int unsigned BIT_WIDTH = 32,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned IDX_W     = 8
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic                      re,
  input  logic [IDX_W-1:0]          idx,
  input  logic [BIT_WIDTH-1:0]      wdata,
  input  logic [BIT_WIDTH/8-1:0]    be,
  output logic [BIT_WIDTH-1:0]      rdata
);

  localparam int unsigned BE_W = be_width_f(BIT_WIDTH);

  logic [BIT_WIDTH-1:0] mem_r [DEPTH];
  logic [BIT_WIDTH-1:0] rdata_r;

  // Byte-lane write port
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be[i]) begin
          mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Registered read port; output holds until the next read
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_r <= mem_r[idx];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder for the datapath load/store port:
// one request at a time, DELAY wait states, then a held response.
module data_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int unsigned BIT_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned DELAY      = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [BIT_WIDTH-1:0]    req_wdata,
  input  logic [BIT_WIDTH/8-1:0]  req_be,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [BIT_WIDTH-1:0]    resp_rdata,
  output logic                    resp_err
);

  localparam int unsigned BE_W   = be_width_f(BIT_WIDTH);
  localparam int unsigned OFF_W  = clog2_f(BE_W);
  localparam int unsigned IDX_W  = (clog2_f(DEPTH) > 0) ? clog2_f(DEPTH) : 1;
  localparam logic        HAS_DELAY  = (DELAY > 0) ? 1'b1 : 1'b0;
  localparam logic [7:0]  DELAY_INIT = (DELAY > 0) ? 8'(DELAY - 1) : 8'd0;
  localparam logic [ADDR_WIDTH:0]   LIMIT     = (ADDR_WIDTH+1)'(DEPTH * BE_W);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MSK = ADDR_WIDTH'(BE_W - 1);

  state_t                  state_r;
  state_t                  next_s;
  logic [7:0]              cnt_r;
  logic                    we_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [BIT_WIDTH-1:0]    wdata_r;
  logic [BE_W-1:0]         be_r;
  logic                    req_ready_r;
  logic                    resp_valid_r;
  logic                    resp_err_r;
  logic                    rd_ok_r;

  logic                    accept_s;
  logic                    err_s;
  logic [IDX_W-1:0]        idx_s;
  logic                    ram_we_s;
  logic                    ram_re_s;
  logic [BIT_WIDTH-1:0]    ram_rdata_s;

  assign accept_s = req_valid && req_ready_r;
  assign err_s    = ((addr_r & ALIGN_MSK) != '0) || ({1'b0, addr_r} >= LIMIT);
  assign idx_s    = addr_r[OFF_W +: IDX_W];

  // A reset landing in the access cycle must not disturb memory.
  assign ram_we_s = (state_r == S_ACCESS) && we_r && !err_s && !rst;
  assign ram_re_s = (state_r == S_ACCESS) && !we_r && !err_s;

  // Next-state selection
  always_comb begin
    next_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          next_s = HAS_DELAY ? S_WAIT : S_ACCESS;
        end else begin
          next_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == 8'd0) begin
          next_s = S_ACCESS;
        end else begin
          next_s = S_WAIT;
        end
      end
      S_ACCESS: next_s = S_RESP;
      S_RESP: begin
        if (resp_ready) begin
          next_s = S_IDLE;
        end else begin
          next_s = S_RESP;
        end
      end
      default: next_s = S_IDLE;
    endcase
  end

  // State, request capture and wait-state counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_IDLE;
      req_ready_r <= 1'b0;
      cnt_r       <= 8'd0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      be_r        <= '0;
    end else begin
      state_r     <= next_s;
      req_ready_r <= (next_s == S_IDLE);
      if (accept_s) begin
        we_r    <= req_we;
        addr_r  <= req_addr;
        wdata_r <= req_wdata;
        be_r    <= req_be;
        cnt_r   <= DELAY_INIT;
      end else if ((state_r == S_WAIT) && (cnt_r != 8'd0)) begin
        cnt_r <= cnt_r - 8'd1;
      end
    end
  end

  // Response flags: loaded at the end of the access cycle, cleared on handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      rd_ok_r      <= 1'b0;
    end else if (state_r == S_ACCESS) begin
      resp_valid_r <= 1'b1;
      resp_err_r   <= err_s;
      rd_ok_r      <= !we_r && !err_s;
    end else if ((state_r == S_RESP) && resp_ready) begin
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      rd_ok_r      <= 1'b0;
    end
  end

  data_mem_ram #(
    .BIT_WIDTH (BIT_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .idx   (idx_s),
    .wdata (wdata_r),
    .be    (be_r),
    .rdata (ram_rdata_s)
  );

  // RAM output register only carries a read result while rd_ok_r is set.
  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_rdata = rd_ok_r ? ram_rdata_s : '0;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with no wait states,
// one with three, checked with immediate assertions.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst0, v0, rdy0, we0, rv0, rr0, er0;
  logic [31:0] addr0, wd0, rd0;
  logic [3:0]  be0;
  logic        rst3, v3, rdy3, we3, rv3, rr3, er3;
  logic [31:0] addr3, wd3, rd3;
  logic [3:0]  be3;

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_responder #(.BIT_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .DELAY(0)) u0 (
    .clk(clk), .rst(rst0), .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_addr(addr0), .req_wdata(wd0), .req_be(be0), .resp_valid(rv0),
    .resp_ready(rr0), .resp_rdata(rd0), .resp_err(er0));

  data_mem_responder #(.BIT_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(256), .DELAY(3)) u3 (
    .clk(clk), .rst(rst3), .req_valid(v3), .req_ready(rdy3), .req_we(we3),
    .req_addr(addr3), .req_wdata(wd3), .req_be(be3), .resp_valid(rv3),
    .resp_ready(rr3), .resp_rdata(rd3), .resp_err(er3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be);
    if (d == 0) begin
      v0 = v; we0 = we; addr0 = a; wd0 = wd; be0 = be;
    end else begin
      v3 = v; we3 = we; addr3 = a; wd3 = wd; be3 = be;
    end
  endtask

  // Issues one request at edge N (driven just after it) with resp_ready high;
  // lat counts edges from N to the first edge after which resp_valid is seen.
  task automatic txn(input int d, input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rdata, output logic err,
                     output int lat, output int rdy_hi);
    int n;
    n = 0;
    while (!((d == 0) ? rdy0 : rdy3) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    drive(d, 1'b1, we, a, wd, be);
    @(posedge clk); #1;
    drive(d, 1'b0, 1'b1, 32'hFFFF_FFF3, 32'hA5A5_A5A5, 4'hF);
    lat = 1;
    rdy_hi = 0;
    while (!((d == 0) ? rv0 : rv3) && lat < 40) begin
      if ((d == 0) ? rdy0 : rdy3) rdy_hi++;
      @(posedge clk); #1; lat++;
    end
    if ((d == 0) ? rdy0 : rdy3) rdy_hi++;
    rdata = (d == 0) ? rd0 : rd3;
    err   = (d == 0) ? er0 : er3;
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          rh;
  int          seen;

  initial begin
    rst0 = 1'b1; rst3 = 1'b1; rr0 = 1'b1; rr3 = 1'b1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready0", {31'd0, rdy0}, 32'd0);
    check("rst_valid0", {31'd0, rv0}, 32'd0);
    check("rst_err0", {31'd0, er0}, 32'd0);
    check("rst_rdata0", rd0, 32'd0);
    check("rst_ready3", {31'd0, rdy3}, 32'd0);
    check("rst_valid3", {31'd0, rv3}, 32'd0);
    rst0 = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;
    check("ready_after_rst", {31'd0, rdy0}, 32'd1);

    // DELAY=0 basic write / read
    txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat, rh);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_err", {31'd0, er}, 32'd0);
    check("wr_rdata", rd, 32'd0);
    check("wr_resp_drop", {31'd0, rv0}, 32'd0);
    txn(0, 1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat, rh);
    check("rd_lat", 32'(lat), 32'd2);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_err", {31'd0, er}, 32'd0);

    // Byte-lane write
    txn(0, 1'b1, 32'h10, 32'h0000_AA00, 4'b0010, rd, er, lat, rh);
    txn(0, 1'b0, 32'h10, 32'd0, 4'h0, rd, er, lat, rh);
    check("be_rd_data", rd, 32'hDEAD_AAEF);

    // Errors and an empty byte-enable
    txn(0, 1'b1, 32'h0, 32'h0102_0304, 4'hF, rd, er, lat, rh);
    txn(0, 1'b0, 32'h12, 32'd0, 4'h0, rd, er, lat, rh);
    check("misalign_err", {31'd0, er}, 32'd1);
    check("misalign_rdata", rd, 32'd0);
    txn(0, 1'b1, 32'h400, 32'h1111_1111, 4'hF, rd, er, lat, rh);
    check("range_err", {31'd0, er}, 32'd1);
    txn(0, 1'b0, 32'h0, 32'd0, 4'h0, rd, er, lat, rh);
    check("range_nowrite", rd, 32'h0102_0304);
    check("range_nowrite_err", {31'd0, er}, 32'd0);
    txn(0, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'h0, rd, er, lat, rh);
    check("be0_err", {31'd0, er}, 32'd0);
    txn(0, 1'b0, 32'h0, 32'd0, 4'h0, rd, er, lat, rh);
    check("be0_nochange", rd, 32'h0102_0304);

    // Backpressure with a second request held valid
    rr0 = 1'b0;
    drive(0, 1'b1, 1'b0, 32'h10, 32'd0, 4'h0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h0, 32'd0, 4'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", {31'd0, rv0}, 32'd1);
      check("bp_rdata", rd0, 32'hDEAD_AAEF);
      check("bp_ready", {31'd0, rdy0}, 32'd0);
      @(posedge clk); #1;
    end
    rr0 = 1'b1;
    @(posedge clk); #1;
    check("bp_hs_valid", {31'd0, rv0}, 32'd0);
    check("bp_hs_rdata", rd0, 32'd0);
    check("bp_hs_ready", {31'd0, rdy0}, 32'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    check("bp_second_taken", {31'd0, rdy0}, 32'd0);
    @(posedge clk); #1;
    check("bp_second_valid", {31'd0, rv0}, 32'd1);
    check("bp_second_rdata", rd0, 32'h0102_0304);
    @(posedge clk); #1;
    check("bp_second_done", {31'd0, rv0}, 32'd0);

    // DELAY=3 latency and ready-low window
    txn(3, 1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, rd, er, lat, rh);
    check("d3_wr_lat", 32'(lat), 32'd5);
    check("d3_wr_ready_low", 32'(rh), 32'd0);
    txn(3, 1'b0, 32'h20, 32'd0, 4'h0, rd, er, lat, rh);
    check("d3_rd_lat", 32'(lat), 32'd5);
    check("d3_rd_ready_low", 32'(rh), 32'd0);
    check("d3_rd_data", rd, 32'hCAFE_F00D);

    // Reset during WAIT abandons the write
    drive(3, 1'b1, 1'b1, 32'h20, 32'h1234_5678, 4'hF);
    @(posedge clk); #1;
    drive(3, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    check("mid_rst_ready", {31'd0, rdy3}, 32'd0);
    check("mid_rst_valid", {31'd0, rv3}, 32'd0);
    check("mid_rst_rdata", rd3, 32'd0);
    check("mid_rst_err", {31'd0, er3}, 32'd0);
    rst3 = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (rv3) seen++;
    end
    check("mid_rst_no_resp", 32'(seen), 32'd0);
    check("mid_rst_ready_back", {31'd0, rdy3}, 32'd1);
    txn(3, 1'b0, 32'h20, 32'd0, 4'h0, rd, er, lat, rh);
    check("mid_rst_mem_kept", rd, 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
